// File: rtl/ham_pkg.sv
// rtl/ham_pkg.sv - shared widths, syndrome codes, FSM states and syndrome helper for ham_rx_ctrl
package ham_pkg;
    localparam int CW_W      = 14;
    localparam int PCM_W     = 8;
    localparam int NIB_CW_W  = 7;
    localparam int CNT_W     = 16;
    localparam int BIT_CNT_W = $clog2(CW_W);

    localparam logic [2:0] SYN_D3 = 3'b111;
    localparam logic [2:0] SYN_D2 = 3'b110;
    localparam logic [2:0] SYN_D1 = 3'b101;
    localparam logic [2:0] SYN_D0 = 3'b011;
    localparam logic [2:0] SYN_P2 = 3'b100;
    localparam logic [2:0] SYN_P1 = 3'b010;
    localparam logic [2:0] SYN_P0 = 3'b001;

    typedef enum logic [1:0] {IDLE, SHIFT, DECODE, HOLD} rx_state_t;

    // Half-codeword layout: [6:3] = d3..d0, [2:0] = p2..p0
    function automatic logic [2:0] ham_syn7(input logic [NIB_CW_W-1:0] cw);
        logic [2:0] syn;
        syn[2] = cw[2] ^ cw[6] ^ cw[5] ^ cw[4];
        syn[1] = cw[1] ^ cw[6] ^ cw[5] ^ cw[3];
        syn[0] = cw[0] ^ cw[6] ^ cw[4] ^ cw[3];
        return syn;
    endfunction

    function automatic logic syn_is_data(input logic [2:0] syn);
        return (syn == SYN_D3) || (syn == SYN_D2) || (syn == SYN_D1) || (syn == SYN_D0);
    endfunction
endpackage

// File: rtl/ham_rx_ctrl_decode.sv
// rtl/ham_rx_ctrl_decode.sv - combinational (7,4)x2 Hamming decoder, single-bit correction per half
module ham_rx_ctrl_decode
    import ham_pkg::*;
(
    input  logic [CW_W-1:0]  cw,
    output logic [PCM_W-1:0] data
);
    function automatic logic [3:0] fix7(input logic [NIB_CW_W-1:0] half);
        logic [3:0] flip;
        case (ham_syn7(half))
            SYN_D3:                         flip = 4'b1000;
            SYN_D2:                         flip = 4'b0100;
            SYN_D1:                         flip = 4'b0010;
            SYN_D0:                         flip = 4'b0001;
            SYN_P2, SYN_P1, SYN_P0, 3'b000: flip = 4'b0000;
            default:                        flip = 4'b0000;
        endcase
        return half[6:3] ^ flip;
    endfunction

    assign data = {fix7(cw[CW_W-1:NIB_CW_W]), fix7(cw[NIB_CW_W-1:0])};
endmodule

// File: rtl/ham_rx_ctrl.sv
// rtl/ham_rx_ctrl.sv - Hamming receive frame controller; define HAM_RX_ERR_CNT_EN to enable err_cnt
module ham_rx_ctrl
    import ham_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             frm_sync,
    output logic [PCM_W-1:0] pcm_data,
    output logic             pcm_vld,
    input  logic             pcm_rdy,
    output logic             pcm_corr,
    output logic             ovf,
    output logic             sync_slip,
    output logic [CNT_W-1:0] err_cnt
);
    rx_state_t            state, state_nxt;
    logic [CW_W-2:0]      shift_reg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [CW_W-1:0]      cap_reg;
    logic [PCM_W-1:0]     dec_data;
    logic                 bit_take, word_done, word_take, slip, dec_corr;

    assign bit_take  = bit_vld && (state != IDLE || frm_sync);
    assign slip      = bit_take && frm_sync && (bit_cnt != '0);
    assign word_done = bit_take && !frm_sync && (bit_cnt == BIT_CNT_W'(CW_W - 1));
    // A finished word is only kept if the capture register is free or being drained now
    assign word_take = word_done && (state == SHIFT || (state == HOLD && pcm_rdy));
    assign dec_corr  = syn_is_data(ham_syn7(cap_reg[CW_W-1:NIB_CW_W])) ||
                       syn_is_data(ham_syn7(cap_reg[NIB_CW_W-1:0]));

    ham_rx_ctrl_decode u_decode (
        .cw   (cap_reg),
        .data (dec_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pcm_vld   = 1'b0;
        case (state)
            IDLE:   if (bit_vld && frm_sync) state_nxt = SHIFT;
            SHIFT:  if (word_take) state_nxt = DECODE;
            DECODE: state_nxt = HOLD;
            HOLD: begin
                pcm_vld = 1'b1;
                if (word_take)    state_nxt = DECODE;
                else if (pcm_rdy) state_nxt = SHIFT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            cap_reg   <= '0;
            pcm_data  <= '0;
            pcm_corr  <= 1'b0;
            ovf       <= 1'b0;
            sync_slip <= 1'b0;
        end else begin
            // The counter alone decides where a word starts, so the shifter never needs clearing
            if (bit_take) begin
                shift_reg <= {shift_reg[CW_W-3:0], bit_in};
                if (frm_sync)
                    bit_cnt <= BIT_CNT_W'(1);
                else if (word_done)
                    bit_cnt <= '0;
                else
                    bit_cnt <= bit_cnt + 1'b1;
            end
            if (word_take)
                cap_reg <= {shift_reg, bit_in};
            if (state == DECODE) begin
                pcm_data <= dec_data;
                pcm_corr <= dec_corr;
            end
            if (word_done && state == HOLD && !pcm_rdy)
                ovf <= 1'b1;
            sync_slip <= slip;
        end
    end

`ifdef HAM_RX_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (pcm_vld && pcm_rdy && pcm_corr && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_ham_rx_ctrl.sv
// tb/tb_ham_rx_ctrl.sv - self-checking bench for ham_rx_ctrl against a nearest-codeword reference model
module tb_ham_rx_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_vld = 1'b0;
    logic        frm_sync = 1'b0;
    logic        pcm_rdy = 1'b0;
    logic [7:0]  pcm_data;
    logic        pcm_vld;
    logic        pcm_corr;
    logic        ovf;
    logic        sync_slip;
    logic [15:0] err_cnt;

    int checks = 0;
    int passes = 0;
    int exp_err = 0;

`ifdef HAM_RX_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    ham_rx_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_vld   (bit_vld),
        .frm_sync  (frm_sync),
        .pcm_data  (pcm_data),
        .pcm_vld   (pcm_vld),
        .pcm_rdy   (pcm_rdy),
        .pcm_corr  (pcm_corr),
        .ovf       (ovf),
        .sync_slip (sync_slip),
        .err_cnt   (err_cnt)
    );

    // Each parity bit covers the data bits whose syndrome code contains that bit
    function automatic logic [6:0] enc7(input logic [3:0] d);
        logic [6:0] c;
        c[6:3] = d;
        c[2]   = d[3] ^ d[2] ^ d[1];
        c[1]   = d[3] ^ d[2] ^ d[0];
        c[0]   = d[3] ^ d[1] ^ d[0];
        return c;
    endfunction

    function automatic logic [13:0] enc14(input logic [7:0] d);
        return {enc7(d[7:4]), enc7(d[3:0])};
    endfunction

    function automatic void ref_dec7(input logic [6:0] rx, output logic [3:0] d, output logic corr);
        d    = rx[6:3];
        corr = 1'b0;
        for (int n = 0; n < 16; n++) begin
            logic [6:0] diff;
            diff = enc7(4'(n)) ^ rx;
            if ($countones(diff) <= 1) begin
                d    = 4'(n);
                corr = |diff[6:3];
            end
        end
    endfunction

    function automatic void ref_dec14(input logic [13:0] rx, output logic [7:0] d, output logic corr);
        logic [3:0] dh, dl;
        logic       ch, cl;
        ref_dec7(rx[13:7], dh, ch);
        ref_dec7(rx[6:0], dl, cl);
        d    = {dh, dl};
        corr = ch | cl;
    endfunction

    task automatic send_bits(input logic [13:0] cw, input int from, input int nbits,
                             input logic sync, input logic b2b);
        for (int i = from; i < from + nbits; i++) begin
            @(negedge clk);
            bit_in   = cw[13 - i];
            bit_vld  = 1'b1;
            frm_sync = sync && (i == from);
            if (!b2b) begin
                @(negedge clk);
                bit_vld  = 1'b0;
                frm_sync = 1'b0;
            end
        end
        if (b2b) begin
            @(negedge clk);
            bit_vld  = 1'b0;
            frm_sync = 1'b0;
        end
    endtask

    task automatic wait_vld(output logic seen);
        int t;
        t = 0;
        while (pcm_vld !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        seen = (pcm_vld === 1'b1);
    endtask

    task automatic accept();
        pcm_rdy = 1'b1;
        @(negedge clk);
        pcm_rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pcm_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_err = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({pcm_data, pcm_vld, pcm_corr, ovf, sync_slip, err_cnt} !== 28'h0)
            $display("FAIL reset_outputs: data=%h vld=%b corr=%b ovf=%b slip=%b cnt=%h, required all 0",
                     pcm_data, pcm_vld, pcm_corr, ovf, sync_slip, err_cnt);
        else passes++;
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [13:0] cws [3]   = '{14'h292D, 14'h392D, 14'h292C};
        logic        corrs [3] = '{1'b0, 1'b1, 1'b0};
        logic        seen;
        for (int v = 0; v < 3; v++) begin
            send_bits(cws[v], 0, 14, 1'b1, v[0]);
            checks++;
            if (pcm_vld !== 1'b0) $display("FAIL vec%0d_lat_n1: vld=%b required 0", v, pcm_vld);
            else passes++;
            @(negedge clk);
            checks++;
            if (pcm_vld !== 1'b1 || pcm_data !== 8'hA5 || pcm_corr !== corrs[v])
                $display("FAIL vec%0d_n2: vld=%b data=%h corr=%b, required vld=1 data=a5 corr=%b",
                         v, pcm_vld, pcm_data, pcm_corr, corrs[v]);
            else passes++;
            repeat (3) @(negedge clk);
            checks++;
            if (pcm_vld !== 1'b1 || pcm_data !== 8'hA5)
                $display("FAIL vec%0d_hold: vld=%b data=%h, required vld=1 data=a5", v, pcm_vld, pcm_data);
            else passes++;
            wait_vld(seen);
            accept();
            if (ERR_EN && corrs[v]) exp_err++;
            checks++;
            if (pcm_vld !== 1'b0 || err_cnt !== 16'(exp_err))
                $display("FAIL vec%0d_accept: vld=%b cnt=%0d, required vld=0 cnt=%0d", v, pcm_vld, err_cnt, exp_err);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic [7:0]  d, ed;
        logic [13:0] cw;
        logic        ec, seen;
        int          pos;
        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom);
            pos = $urandom_range(0, 14);
            cw  = enc14(d);
            if (pos < 14) cw[pos] = ~cw[pos];
            ref_dec14(cw, ed, ec);
            if ($urandom_range(0, 3) == 0) pcm_rdy = 1'b1;
            send_bits(cw, 0, 14, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_vld(seen);
            checks++;
            if (!seen || pcm_data !== ed || pcm_corr !== ec)
                $display("FAIL rand%0d: vld=%b data=%h corr=%b, required vld=1 data=%h corr=%b (cw=%h)",
                         k, seen, pcm_data, pcm_corr, ed, ec, cw);
            else passes++;
            if (pcm_rdy) @(negedge clk);
            else accept();
            pcm_rdy = 1'b0;
            if (ERR_EN && ec) exp_err++;
            checks++;
            if (err_cnt !== 16'(exp_err))
                $display("FAIL rand%0d_cnt: cnt=%0d required %0d", k, err_cnt, exp_err);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  da, db;
        logic [13:0] ca, cb;
        logic        seen;
        do_reset();
        da = 8'($urandom);
        db = da ^ 8'h5A;
        ca = enc14(da);
        ca[10 + $urandom_range(0, 3)] ^= 1'b1;
        cb = enc14(db);
        send_bits(ca, 0, 14, 1'b1, 1'b1);
        wait_vld(seen);
        send_bits(cb, 0, 13, 1'b0, 1'b1);
        bit_in  = cb[0];
        bit_vld = 1'b1;
        pcm_rdy = 1'b1;
        @(negedge clk);
        bit_vld = 1'b0;
        pcm_rdy = 1'b0;
        if (ERR_EN) exp_err++;
        @(negedge clk);
        checks++;
        if (pcm_vld !== 1'b1 || pcm_data !== db || pcm_corr !== 1'b0 || ovf !== 1'b0)
            $display("FAIL b2b_second: vld=%b data=%h corr=%b ovf=%b, required vld=1 data=%h corr=0 ovf=0",
                     pcm_vld, pcm_data, pcm_corr, ovf, db);
        else passes++;
        checks++;
        if (err_cnt !== 16'(exp_err)) $display("FAIL b2b_cnt: cnt=%0d required %0d", err_cnt, exp_err);
        else passes++;
        accept();
    endtask

    task automatic test_overflow();
        logic [7:0] dc, de;
        logic       seen, any_vld;
        dc = 8'($urandom);
        de = 8'($urandom);
        send_bits(enc14(dc), 0, 14, 1'b0, 1'b1);
        wait_vld(seen);
        send_bits(enc14(dc ^ 8'hFF), 0, 14, 1'b0, 1'b1);
        checks++;
        if (ovf !== 1'b1 || pcm_vld !== 1'b1 || pcm_data !== dc)
            $display("FAIL ovf_set: ovf=%b vld=%b data=%h, required ovf=1 vld=1 data=%h", ovf, pcm_vld, pcm_data, dc);
        else passes++;
        accept();
        any_vld = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any_vld |= pcm_vld;
        end
        checks++;
        if (any_vld !== 1'b0 || ovf !== 1'b1)
            $display("FAIL ovf_drop: late_vld=%b ovf=%b, required late_vld=0 ovf=1", any_vld, ovf);
        else passes++;
        send_bits(enc14(de), 0, 14, 1'b0, 1'b0);
        wait_vld(seen);
        checks++;
        if (!seen || pcm_data !== de) $display("FAIL hold_before_rst: vld=%b data=%h required 1 %h", seen, pcm_data, de);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pcm_data, pcm_vld, pcm_corr, ovf, sync_slip, err_cnt} !== 28'h0)
            $display("FAIL rst_in_hold: data=%h vld=%b corr=%b ovf=%b slip=%b cnt=%h, required all 0",
                     pcm_data, pcm_vld, pcm_corr, ovf, sync_slip, err_cnt);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_err = 0;
    endtask

    task automatic test_sync_slip();
        logic [7:0]  d;
        logic [13:0] cw;
        logic        seen;
        do_reset();
        d  = 8'($urandom);
        cw = enc14(d);
        send_bits(14'($urandom), 0, 5, 1'b1, 1'b0);
        @(negedge clk);
        bit_in   = cw[13];
        bit_vld  = 1'b1;
        frm_sync = 1'b1;
        @(negedge clk);
        bit_vld  = 1'b0;
        frm_sync = 1'b0;
        checks++;
        if (sync_slip !== 1'b1) $display("FAIL slip_pulse: slip=%b required 1", sync_slip);
        else passes++;
        @(negedge clk);
        checks++;
        if (sync_slip !== 1'b0) $display("FAIL slip_width: slip=%b required 0", sync_slip);
        else passes++;
        send_bits(cw, 1, 13, 1'b0, 1'b0);
        wait_vld(seen);
        checks++;
        if (!seen || pcm_data !== d || pcm_corr !== 1'b0)
            $display("FAIL slip_word: vld=%b data=%h corr=%b, required vld=1 data=%h corr=0", seen, pcm_data, pcm_corr, d);
        else passes++;
        accept();
        @(negedge clk);
        bit_in   = 1'b1;
        bit_vld  = 1'b1;
        frm_sync = 1'b1;
        @(negedge clk);
        bit_vld  = 1'b0;
        frm_sync = 1'b0;
        checks++;
        if (sync_slip !== 1'b0) $display("FAIL slip_aligned: slip=%b required 0", sync_slip);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [7:0]  d;
        logic        seen, any_vld;
        do_reset();
        d = 8'($urandom);
        send_bits(enc14(d), 0, 7, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pcm_data, pcm_vld, pcm_corr, ovf, sync_slip, err_cnt} !== 28'h0)
            $display("FAIL rst_mid_word: outputs=%h required 0", {pcm_data, pcm_vld, pcm_corr, ovf, sync_slip, err_cnt});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        any_vld = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bit_in  = 1'($urandom);
            bit_vld = 1'b1;
            @(negedge clk);
            bit_vld = 1'b0;
            any_vld |= pcm_vld;
        end
        repeat (5) begin
            @(negedge clk);
            any_vld |= pcm_vld;
        end
        checks++;
        if (any_vld !== 1'b0) $display("FAIL idle_ignore: vld seen=%b required 0", any_vld);
        else passes++;
        send_bits(enc14(d), 0, 14, 1'b1, 1'b1);
        wait_vld(seen);
        checks++;
        if (!seen || pcm_data !== d) $display("FAIL after_rst_word: vld=%b data=%h required 1 %h", seen, pcm_data, d);
        else passes++;
        accept();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_overflow();
        test_sync_slip();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
